sa_cache_ctrl: RTL
==================

Name: sa_cache_ctrl

Overview:
Miss/replacement controller for the 4-way set-associative cache (sa_cache). It accepts one CPU access at a time and evaluates the tag-compare results from the cache datapath. It sequences hit completion, dirty-victim writeback and line refill over a request/response memory handshake, and owns the per-set tree pseudo-LRU state. It drives way select and array write enables into the data, tag and dirty arrays, and keeps hit/miss statistics.

Parameters:
NUM_SETS, 16, number of sets; power of two, minimum 2.
INDEX_W, 4, log2(NUM_SETS).
CNT_W, 16, width of the saturating hit and miss counters.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
i_req_valid  in  1  CPU access request.
o_req_ready  out  1  controller can accept a request; high only in IDLE.
i_req_we  in  1  1 = write (memRW), 0 = read; latched at accept.
i_index  in  INDEX_W  set index; latched at accept.
i_hit_way  in  4  per-way valid&tag-match for the latched index; sampled in LOOKUP.
i_valid_way  in  4  per-way valid bits of the latched set; sampled in LOOKUP.
i_dirty_way  in  4  per-way dirty bits of the latched set; sampled in LOOKUP.
o_way_sel  out  2  way addressed by the current array or memory operation.
o_data_we  out  1  data array line/word write strobe.
o_tag_we  out  1  tag write strobe; sets valid and clears dirty for o_way_sel.
o_dirty_set  out  1  sets the dirty bit for o_way_sel.
o_mem_req  out  1  memory request, held until acknowledged.
o_mem_we  out  1  1 = writeback of the victim line, 0 = line fetch.
i_mem_resp  in  1  memory acknowledge/data valid, single-cycle pulse.
o_done  out  1  one-cycle access-complete pulse.
o_hit  out  1  qualifies o_done; 1 = access hit.
o_hit_cnt  out  CNT_W  saturating hit count.
o_miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Reset (rst low, async): state = IDLE; all PLRU bits = 0; counters = 0; every output = 0 except o_req_ready.
- o_req_ready is 1 after reset releases. Reset mid-transaction drops o_mem_req immediately and abandons the access without a done pulse.
- FSM states: IDLE, LOOKUP, HIT, WB, REFILL, UPDATE, DONE_MISS.
- IDLE: o_req_ready = 1. On i_req_valid at a clock edge, latch i_req_we and i_index, then go to LOOKUP. Requests are ignored in every other state.
- LOOKUP (1 cycle):
  - If i_hit_way != 0, way = lowest set bit, go to HIT.
  - Else the victim is the lowest-indexed way with i_valid_way = 0. If all ways are valid, the victim is the PLRU way. The victim is registered as way.
  - Next state is WB if i_dirty_way[victim] = 1, else REFILL.
- HIT (1 cycle): o_done = 1, o_hit = 1, o_way_sel = way. If the access is a write, o_data_we = 1 and o_dirty_set = 1. Update PLRU, hit_cnt += 1, go to IDLE.
- Hit latency: the accept edge is followed by one LOOKUP cycle, and o_done is high in the second cycle after accept.
- WB: o_mem_req = 1, o_mem_we = 1, o_way_sel = victim. When i_mem_resp is sampled high, go to REFILL.
- REFILL: o_mem_req = 1, o_mem_we = 0. When i_mem_resp is sampled high, go to UPDATE. o_mem_req deasserts in the cycle after the response.
- UPDATE (1 cycle): o_data_we = 1, o_tag_we = 1, o_way_sel = victim. Go to DONE_MISS.
- DONE_MISS (1 cycle): o_done = 1, o_hit = 0. For a write, o_data_we = 1 and o_dirty_set = 1 to merge the write word. Update PLRU, miss_cnt += 1, go to IDLE.
- PLRU: 3 bits {b0,b1,b2} per set.
  - Victim: if b0 = 0 then (b1 ? way1 : way0), else (b2 ? way3 : way2).
  - Access to way w sets b0 = (w < 2). If w < 2, b1 = (w == 0); otherwise b2 = (w == 2).
  - Only the latched set is updated.
- i_mem_resp outside WB/REFILL is ignored. o_mem_req never deasserts before a response except on reset.
- Counters saturate at all-ones; there is no wrap.

Test Plan:
- Reset: drive rst low mid-REFILL → o_mem_req falls without a clock edge. After release: o_req_ready = 1, counters = 0, all other outputs 0.
- Cold read miss, set 3, i_valid_way = 0000 → victim way0, REFILL with o_mem_we = 0. Response 3 cycles later → UPDATE with o_tag_we = 1, o_way_sel = 0, then o_done = 1, o_hit = 0, o_miss_cnt = 1.
- Write hit, i_hit_way = 0100 → o_done and o_hit in the second cycle after accept, o_way_sel = 2, o_data_we = 1, o_dirty_set = 1, o_hit_cnt = 1.
- PLRU, set 5: all valid and clean, hit way0 then hit way2, then a miss → victim way1. With fresh PLRU and all valid, the victim is way0.
- Dirty victim: all valid, i_dirty_way = 0001, fresh PLRU → WB with o_mem_we = 1, o_way_sel = 0. Response → REFILL with o_mem_we = 0, then UPDATE and DONE_MISS.
- Back-to-back: i_req_valid held high → o_req_ready is low from LOOKUP through completion, and the next request is accepted only in IDLE. A stray i_mem_resp during HIT has no effect.

Source files
------------

// File: rtl/sa_cache_ctrl.sv
// Miss/replacement controller for the 4-way set-associative cache: hit completion,
// dirty-victim writeback, line refill, per-set tree pseudo-LRU and hit/miss statistics.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a CPU access; latches we/index on accept
// LOOKUP    | evaluate tag compare, pick hit way or victim
// HIT       | complete a hit (write merges data, sets dirty)
// WB        | write back dirty victim line to memory
// REFILL    | fetch the missing line from memory
// UPDATE    | write refilled line and tag into the victim way
// DONE_MISS | complete the miss (write merges data, sets dirty)
module sa_cache_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int INDEX_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [3:0]         i_hit_way,
  input  logic [3:0]         i_valid_way,
  input  logic [3:0]         i_dirty_way,
  output logic [1:0]         o_way_sel,
  output logic               o_data_we,
  output logic               o_tag_we,
  output logic               o_dirty_set,
  output logic               o_mem_req,
  output logic               o_mem_we,
  input  logic               i_mem_resp,
  output logic               o_done,
  output logic               o_hit,
  output logic [CNT_W-1:0]   o_hit_cnt,
  output logic [CNT_W-1:0]   o_miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_HIT, S_WB, S_REFILL, S_UPDATE, S_DONE_MISS
  } state_t;

  state_t             state, state_nxt;
  logic               we_q;
  logic [INDEX_W-1:0] index_q;
  logic [1:0]         way_q;
  logic [2:0]         plru_q [NUM_SETS];
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;

  logic [1:0] hit_idx, free_idx, plru_way, victim_way, lookup_way;
  logic       any_free;
  logic [2:0] plru_cur;

  // plru bit 0 = b0 (root), bit 1 = b1 (ways 0/1), bit 2 = b2 (ways 2/3)
  function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] r;
    r    = cur;
    r[0] = ~w[1];
    if (!w[1]) r[1] = (w == 2'd0);
    else       r[2] = (w == 2'd2);
    return r;
  endfunction

  always_comb begin
    hit_idx  = 2'd0;
    free_idx = 2'd0;
    any_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (i_hit_way[i])    hit_idx  = 2'(i);
      if (!i_valid_way[i]) begin
        free_idx = 2'(i);
        any_free = 1'b1;
      end
    end
    plru_cur   = plru_q[index_q];
    plru_way   = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2) : (plru_cur[1] ? 2'd1 : 2'd0);
    victim_way = any_free ? free_idx : plru_way;
    lookup_way = (|i_hit_way) ? hit_idx : victim_way;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (|i_hit_way)                   state_nxt = S_HIT;
        else if (i_dirty_way[victim_way]) state_nxt = S_WB;
        else                              state_nxt = S_REFILL;
      end
      S_HIT:       state_nxt = S_IDLE;
      S_WB:        if (i_mem_resp) state_nxt = S_REFILL;
      S_REFILL:    if (i_mem_resp) state_nxt = S_UPDATE;
      S_UPDATE:    state_nxt = S_DONE_MISS;
      S_DONE_MISS: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      index_q  <= '0;
      way_q    <= 2'd0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= 3'b000;
    end else begin
      if (state == S_IDLE && i_req_valid) begin
        we_q    <= i_req_we;
        index_q <= i_index;
      end
      if (state == S_LOOKUP) way_q <= lookup_way;
      if (state == S_HIT || state == S_DONE_MISS)
        plru_q[index_q] <= plru_touch(plru_q[index_q], way_q);
      if (state == S_HIT && hit_cnt != '1)
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (state == S_DONE_MISS && miss_cnt != '1)
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_way_sel   = 2'd0;
    o_data_we   = 1'b0;
    o_tag_we    = 1'b0;
    o_dirty_set = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_done      = 1'b0;
    o_hit       = 1'b0;
    case (state)
      S_IDLE:   o_req_ready = 1'b1;
      S_HIT: begin
        o_way_sel   = way_q;
        o_done      = 1'b1;
        o_hit       = 1'b1;
        o_data_we   = we_q;
        o_dirty_set = we_q;
      end
      S_WB: begin
        o_way_sel = way_q;
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
      end
      S_REFILL: begin
        o_way_sel = way_q;
        o_mem_req = 1'b1;
      end
      S_UPDATE: begin
        o_way_sel = way_q;
        o_data_we = 1'b1;
        o_tag_we  = 1'b1;
      end
      S_DONE_MISS: begin
        o_way_sel   = way_q;
        o_done      = 1'b1;
        o_data_we   = we_q;
        o_dirty_set = we_q;
      end
      default: ;
    endcase
  end

  assign o_hit_cnt  = hit_cnt;
  assign o_miss_cnt = miss_cnt;

endmodule
